cache_arbiter: RTL and testbench

Arbitrates the single shared physical-memory port between the instruction-fetch L1 cache (port A) and the data L1 cache (port B) of the LC-3b pipeline. It accepts whole-line read/write miss requests from both caches, grants one at a time with round-robin fairness, and registers address, write data and read data. It returns a one-cycle response to the winner. From the hazard logic's view, it produces the `mem_resp_a` / `mem_resp_b` timing that drives `mem_miss_a` / `mem_miss_b`.

---
 rtl/lc3b_types.sv | 28 ++
 rtl/sat_counter16.sv | 29 ++
 rtl/cache_arbiter.sv | 156 +++++++++++++++
 tb/tb_cache_arbiter.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/lc3b_types.sv
// Shared LC-3b types for the memory-side arbiter: word/line widths, FSM state,
// grant owner and request kind.
package lc3b_types;

  typedef logic [15:0]  lc3b_word;
  typedef logic [127:0] lc3b_line;

  typedef enum logic [2:0] {
    IDLE,
    BUSY_A,
    BUSY_B,
    RESP_A,
    RESP_B
  } arb_state_t;

  typedef enum logic {
    GRANT_A,
    GRANT_B
  } arb_grant_t;

  typedef enum logic {
    OP_READ,
    OP_WRITE
  } arb_op_t;

  localparam lc3b_word STALL_MAX = 16'hFFFF;

endpackage

// File: rtl/sat_counter16.sv
// 16-bit up counter with enable and synchronous clear that holds at STALL_MAX
// instead of wrapping.
module sat_counter16
  import lc3b_types::*;
(
  input  logic     clk,
  input  logic     clear,
  input  logic     en,
  output lc3b_word count
);

  lc3b_word count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (en && (count_q != STALL_MAX)) begin
      count_d = count_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/cache_arbiter.sv
// Round-robin arbiter sharing one physical-memory port between the I-cache (A)
// and D-cache (B); registers address, write line and returned read line.
module cache_arbiter
  import lc3b_types::*;
(
  input  logic     clk,
  input  logic     reset,
  input  logic     a_read,
  input  lc3b_word a_address,
  output lc3b_line a_rdata,
  output logic     a_resp,
  input  logic     b_read,
  input  logic     b_write,
  input  lc3b_word b_address,
  input  lc3b_line b_wdata,
  output lc3b_line b_rdata,
  output logic     b_resp,
  output logic     pmem_read,
  output logic     pmem_write,
  output lc3b_word pmem_address,
  output lc3b_line pmem_wdata,
  input  lc3b_line pmem_rdata,
  input  logic     pmem_resp,
  output lc3b_word stall_a_cycles,
  output lc3b_word stall_b_cycles
);

  arb_state_t state_q, state_d;
  arb_grant_t last_grant_q, last_grant_d;
  arb_op_t    op_q, op_d;
  lc3b_word   addr_q, addr_d;
  lc3b_line   wdata_q, wdata_d;
  lc3b_line   line_q, line_d;
  logic       a_resp_q, a_resp_d;
  logic       b_resp_q, b_resp_d;
  logic       pmem_read_q, pmem_read_d;
  logic       pmem_write_q, pmem_write_d;

  logic a_pend, b_pend, grant_b, busy_d;

  assign a_pend = a_read;
  assign b_pend = b_read | b_write;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    op_d         = op_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    line_d       = line_q;
    a_resp_d     = 1'b0;
    b_resp_d     = 1'b0;
    grant_b      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (a_pend || b_pend) begin
          grant_b = b_pend && (!a_pend || (last_grant_q == GRANT_A));
          if (grant_b) begin
            state_d      = BUSY_B;
            last_grant_d = GRANT_B;
            addr_d       = b_address;
            // Illegal read+write is served as a writeback.
            op_d         = b_write ? OP_WRITE : OP_READ;
            if (b_write) begin
              wdata_d = b_wdata;
            end
          end else begin
            state_d      = BUSY_A;
            last_grant_d = GRANT_A;
            addr_d       = a_address;
            op_d         = OP_READ;
          end
        end
      end
      BUSY_A: begin
        if (pmem_resp) begin
          line_d   = pmem_rdata;
          state_d  = RESP_A;
          a_resp_d = 1'b1;
        end
      end
      BUSY_B: begin
        if (pmem_resp) begin
          line_d   = pmem_rdata;
          state_d  = RESP_B;
          b_resp_d = 1'b1;
        end
      end
      RESP_A, RESP_B: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Strobes are registered from next-state so they rise the cycle after grant.
    busy_d       = (state_d == BUSY_A) || (state_d == BUSY_B);
    pmem_read_d  = busy_d && (op_d == OP_READ);
    pmem_write_d = busy_d && (op_d == OP_WRITE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      last_grant_q <= GRANT_A;
      op_q         <= OP_READ;
      addr_q       <= '0;
      wdata_q      <= '0;
      line_q       <= '0;
      a_resp_q     <= 1'b0;
      b_resp_q     <= 1'b0;
      pmem_read_q  <= 1'b0;
      pmem_write_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      op_q         <= op_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      line_q       <= line_d;
      a_resp_q     <= a_resp_d;
      b_resp_q     <= b_resp_d;
      pmem_read_q  <= pmem_read_d;
      pmem_write_q <= pmem_write_d;
    end
  end

  assign pmem_read    = pmem_read_q;
  assign pmem_write   = pmem_write_q;
  assign pmem_address = addr_q;
  assign pmem_wdata   = wdata_q;
  assign a_rdata      = line_q;
  assign b_rdata      = line_q;
  assign a_resp       = a_resp_q;
  assign b_resp       = b_resp_q;

  sat_counter16 u_stall_a (
    .clk   (clk),
    .clear (reset),
    .en    (a_pend && (state_q != RESP_A)),
    .count (stall_a_cycles)
  );

  sat_counter16 u_stall_b (
    .clk   (clk),
    .clear (reset),
    .en    (b_pend && (state_q != RESP_B)),
    .count (stall_b_cycles)
  );

  a_no_dual_b_req : assert property (@(posedge clk) disable iff (reset) !(b_read && b_write))
    else $error("cache_arbiter: b_read and b_write asserted together");

endmodule

// File: tb/tb_cache_arbiter.sv
// Scoreboard bench for cache_arbiter: stimulus pushes expected responses, a
// forked monitor pops them on every a_resp/b_resp; a forked model plays memory.
module tb_cache_arbiter;

  typedef struct {
    logic         side_b;
    logic [127:0] line;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset;
  logic         a_read;
  logic [15:0]  a_address;
  logic [127:0] a_rdata;
  logic         a_resp;
  logic         b_read, b_write;
  logic [15:0]  b_address;
  logic [127:0] b_wdata;
  logic [127:0] b_rdata;
  logic         b_resp;
  logic         pmem_read, pmem_write;
  logic [15:0]  pmem_address;
  logic [127:0] pmem_wdata;
  logic [127:0] pmem_rdata;
  logic         pmem_resp;
  logic [15:0]  stall_a_cycles, stall_b_cycles;

  int checks = 0;
  int errors = 0;
  exp_t exp_q[$];

  // memory model controls / observations
  bit           mem_auto   = 1'b1;
  bit           mem_fixed  = 1'b0;
  bit           force_resp = 1'b0;
  int           mem_lat    = 1;
  int           wait_cnt   = 0;
  int           strobe_cnt = 0;
  bit           addr_bad   = 1'b0;
  logic [15:0]  exp_addr   = '0;
  logic         seen_read  = 1'b0;
  logic         seen_write = 1'b0;
  logic [127:0] seen_wdata = '0;

  localparam logic [127:0] FIXED_LINE = 128'hDEAD_1111_2222_3333_4444_5555_6666_BEEF;
  localparam logic [127:0] A5_LINE    = {16{8'hA5}};

  cache_arbiter dut (
    .clk            (clk),
    .reset          (reset),
    .a_read         (a_read),
    .a_address      (a_address),
    .a_rdata        (a_rdata),
    .a_resp         (a_resp),
    .b_read         (b_read),
    .b_write        (b_write),
    .b_address      (b_address),
    .b_wdata        (b_wdata),
    .b_rdata        (b_rdata),
    .b_resp         (b_resp),
    .pmem_read      (pmem_read),
    .pmem_write     (pmem_write),
    .pmem_address   (pmem_address),
    .pmem_wdata     (pmem_wdata),
    .pmem_rdata     (pmem_rdata),
    .pmem_resp      (pmem_resp),
    .stall_a_cycles (stall_a_cycles),
    .stall_b_cycles (stall_b_cycles)
  );

  always #5 clk = ~clk;

  function automatic logic [127:0] rep(input logic [15:0] a);
    return {8{a}};
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic side_b, input logic [127:0] line);
    exp_t e;
    e.side_b = side_b;
    e.line   = line;
    exp_q.push_back(e);
  endtask

  task automatic wait_resp(input logic side_b, input int limit, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(side_b ? b_resp : a_resp) && n < limit);
    chk(side_b ? "b_resp_timeout" : "a_resp_timeout", 128'(side_b ? b_resp : a_resp), 128'(1));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    a_read = 1'b0; b_read = 1'b0; b_write = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // Raise both sides together; each drops its request on seeing its own resp.
  task automatic run_pair(input logic b_first, input logic [15:0] aa, input logic [15:0] ba);
    bit done_a, done_b;
    int cyc;
    a_address = aa; b_address = ba;
    if (b_first) begin
      push_exp(1'b1, rep(ba)); push_exp(1'b0, rep(aa));
    end else begin
      push_exp(1'b0, rep(aa)); push_exp(1'b1, rep(ba));
    end
    a_read = 1'b1; b_read = 1'b1;
    done_a = 1'b0; done_b = 1'b0; cyc = 0;
    while (!(done_a && done_b) && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (a_resp) begin a_read = 1'b0; done_a = 1'b1; end
      if (b_resp) begin b_read = 1'b0; done_b = 1'b1; end
    end
    chk("pair_done", 128'({done_a, done_b}), 128'(2'b11));
  endtask

  initial begin
    int n;
    int c;
    bit any;
    reset = 1'b1; a_read = 1'b0; b_read = 1'b0; b_write = 1'b0;
    a_address = '0; b_address = '0; b_wdata = '0;
    pmem_rdata = '0; pmem_resp = 1'b0;

    fork
      forever begin
        @(negedge clk);
        pmem_resp = 1'b0;
        if (force_resp) begin
          pmem_resp  = 1'b1;
          pmem_rdata = rep(16'hBAD0);
          force_resp = 1'b0;
        end else if (mem_auto && (pmem_read || pmem_write)) begin
          strobe_cnt++;
          if (pmem_address !== exp_addr) addr_bad = 1'b1;
          wait_cnt++;
          if (wait_cnt >= mem_lat) begin
            pmem_resp  = 1'b1;
            pmem_rdata = mem_fixed ? FIXED_LINE : rep(pmem_address);
            seen_read  = pmem_read;
            seen_write = pmem_write;
            seen_wdata = pmem_wdata;
            wait_cnt   = 0;
          end
        end else begin
          wait_cnt = 0;
        end
      end
      forever begin
        @(negedge clk);
        if (a_resp || b_resp) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_resp", 128'({a_resp, b_resp}), 128'(2'b00));
          end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("resp_side", 128'({a_resp, b_resp}), 128'(e.side_b ? 2'b01 : 2'b10));
            chk("resp_line", e.side_b ? b_rdata : a_rdata, e.line);
          end
        end
      end
    join_none

    do_reset();
    chk("rst_strobes", 128'({pmem_read, pmem_write, a_resp, b_resp}), 128'(0));
    chk("rst_paddr", 128'(pmem_address), 128'(0));
    chk("rst_pwdata", pmem_wdata, 128'(0));
    chk("rst_line", a_rdata, 128'(0));
    chk("rst_stall", 128'({stall_a_cycles, stall_b_cycles}), 128'(0));

    // A only, 4-cycle memory, fixed line
    mem_lat = 4; mem_fixed = 1'b1; exp_addr = 16'h1230; strobe_cnt = 0; addr_bad = 1'b0;
    push_exp(1'b0, FIXED_LINE);
    a_address = 16'h1230; a_read = 1'b1;
    wait_resp(1'b0, 50, n);
    a_read = 1'b0;
    chk("a_strobe_cycles", 128'(strobe_cnt), 128'(4));
    chk("a_addr_held", 128'(addr_bad), 128'(0));
    chk("a_is_read", 128'({seen_read, seen_write}), 128'(2'b10));
    chk("a_stall_cnt", 128'(stall_a_cycles), 128'(5));
    chk("a_stall_b_cnt", 128'(stall_b_cycles), 128'(0));
    @(negedge clk);

    // zero-wait memory: resp seen on 2nd falling edge after request
    mem_lat = 1; mem_fixed = 1'b0;
    push_exp(1'b0, rep(16'h0AB0));
    a_address = 16'h0AB0; a_read = 1'b1;
    wait_resp(1'b0, 50, n);
    a_read = 1'b0;
    chk("min_latency", 128'(n), 128'(2));
    @(negedge clk);

    // reset during BUSY_B with a silent memory, then a late pmem_resp
    mem_auto = 1'b0;
    b_address = 16'h5550; b_read = 1'b1;
    c = 0;
    while (!pmem_read && c < 10) begin @(negedge clk); c++; end
    chk("busy_b_entry", 128'(pmem_read), 128'(1));
    reset = 1'b1; b_read = 1'b0;
    @(negedge clk);
    chk("rst_busy_strobes", 128'({pmem_read, pmem_write}), 128'(0));
    chk("rst_busy_paddr", 128'(pmem_address), 128'(0));
    reset = 1'b0; force_resp = 1'b1;
    any = 1'b0;
    repeat (4) begin @(negedge clk); any |= (a_resp | b_resp); end
    chk("late_resp_ignored", 128'(any), 128'(0));
    chk("idle_after_rst", 128'({pmem_read, pmem_write}), 128'(0));
    mem_auto = 1'b1;

    // contention after reset: B, A, then B, A again
    mem_lat = 2;
    run_pair(1'b1, 16'h1110, 16'h2220);
    run_pair(1'b1, 16'h3330, 16'h4440);

    // B writeback
    mem_lat = 2; exp_addr = 16'h4000; strobe_cnt = 0; addr_bad = 1'b0;
    push_exp(1'b1, rep(16'h4000));
    b_address = 16'h4000; b_wdata = A5_LINE; b_write = 1'b1;
    wait_resp(1'b1, 50, n);
    b_write = 1'b0;
    chk("b_is_write", 128'({seen_read, seen_write}), 128'(2'b01));
    chk("b_wdata", seen_wdata, A5_LINE);
    chk("b_addr_held", 128'(addr_bad), 128'(0));
    chk("b_strobe_cycles", 128'(strobe_cnt), 128'(2));
    @(negedge clk);

    // last grant was B, so contention now favours A
    run_pair(1'b0, 16'h5670, 16'h89A0);

    // A moves its address mid-BUSY; downstream must keep the latched one
    mem_lat = 3; exp_addr = 16'h2220; addr_bad = 1'b0;
    push_exp(1'b0, rep(16'h2220));
    a_address = 16'h2220; a_read = 1'b1;
    c = 0;
    while (!pmem_read && c < 10) begin @(negedge clk); c++; end
    a_address = 16'h7770;
    wait_resp(1'b0, 50, n);
    a_read = 1'b0;
    chk("addr_latched", 128'(addr_bad), 128'(0));
    @(negedge clk);

    // long B stall with A pending: both counters saturate
    mem_lat = 70000;
    push_exp(1'b1, rep(16'h6000));
    b_address = 16'h6000; b_wdata = ~A5_LINE; b_write = 1'b1;
    @(negedge clk);
    push_exp(1'b0, rep(16'h0100));
    a_address = 16'h0100; a_read = 1'b1;
    wait_resp(1'b1, 80000, n);
    b_write = 1'b0;
    chk("stall_a_sat", 128'(stall_a_cycles), 128'(16'hFFFF));
    mem_lat = 1;
    wait_resp(1'b0, 20, n);
    a_read = 1'b0;
    @(negedge clk);
    chk("stall_a_hold", 128'(stall_a_cycles), 128'(16'hFFFF));
    chk("stall_b_sat", 128'(stall_b_cycles), 128'(16'hFFFF));

    repeat (3) @(negedge clk);
    chk("sb_drained", 128'(exp_q.size()), 128'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
